immgen_pipe: RTL and testbench
==============================

# immgen_pipe

Parametrised, pipelined RISC-V immediate generator. Decodes every base-ISA immediate format (I, S, B, U, J) plus shift-amount immediates from a 32-bit instruction and produces a sign-extended XLEN-bit immediate. It sits between fetch/decode and the ALU operand mux, behind a one-stage registered valid/ready handshake. It also reports the detected format and keeps a saturating count of instructions with no immediate encoding.

## Interface
- XLEN, 32: immediate output width; legal values 32 or 64.
- CNT_W, 8: width of the illegal-instruction counter.

- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on `instrucao`.
- in_ready  out  1  block can accept an instruction this cycle.
- instrucao  in  32  instruction word.
- out_valid  out  1  `imediatoGerado`, `fmt` and `illegal` are valid.
- out_ready  in  1  consumer accepts the output this cycle.
- imediatoGerado  out  XLEN  generated immediate.
- fmt  out  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH.
- illegal  out  1  opcode has no immediate encoding.
- ill_cnt  out  CNT_W  saturating count of accepted illegal instructions.
- cnt_clear  in  1  synchronous clear of `ill_cnt`.

## Operation
Decode uses opcode `op = instrucao[6:0]` and `f3 = instrucao[14:12]`. "sext" means sign-extend from bit 31 of the instruction to XLEN.

- SH: `op`=0010011 with `f3`=001 or 101. Immediate is the zero-extended shamt.
  - XLEN=32: shamt is `instrucao[24:20]`.
  - XLEN=64: shamt is `instrucao[25:20]`.
  - SH decode takes priority over I decode.
- I: `op` is 0000011, 0010011, 1100111 or 0001111. Immediate is sext(`instrucao[31:20]`).
- S: `op`=0100011. Immediate is sext({`instrucao[31:25]`, `instrucao[11:7]`}).
- B: `op`=1100011. Immediate is sext({`instrucao[31]`, `instrucao[7]`, `instrucao[30:25]`, `instrucao[11:8]`, 1'b0}).
- U: `op` is 0110111 or 0010111. Immediate is sext({`instrucao[31:12]`, 12'b0}).
- J: `op`=1101111. Immediate is sext({`instrucao[31]`, `instrucao[19:12]`, `instrucao[20]`, `instrucao[30:21]`, 1'b0}).
- Any other opcode:
  - immediate 0, `fmt`=NONE, `illegal`=1.
  - Opcode 0110011 (R-type) is also reported as NONE with `illegal`=1. Upstream masks `illegal` for R-type where needed.

Handshake:
- `in_ready` = !`out_valid` || `out_ready` (combinational).
- Accept occurs when `in_valid` && `in_ready`. On accept, the decoded results load into the output register and `out_valid` is set to 1.
- If `out_valid` && `out_ready` with no accept, `out_valid` is set to 0.
- While `out_valid` && !`out_ready`, all outputs hold stable.

Illegal counter:
- Increments by 1 on each accepted illegal instruction.
- Saturates at 2^CNT_W−1.
- `cnt_clear` has priority: a clear coinciding with an illegal accept leaves the counter at 0.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle when `out_ready`=1.
- Reset values: `out_valid`=0, `imediatoGerado`=0, `fmt`=0, `illegal`=0, `ill_cnt`=0. Consequently `in_ready`=1 right after reset.
- Reset mid-operation: a held, unconsumed output is discarded. `in_valid` is ignored in the reset cycle.
- Simultaneous output consume and new accept: the new result replaces the old one and `out_valid` stays 1. No bubble.
- `in_valid`=0: the output register does not load new data; it keeps its previous contents.

## Test plan
- Reset, then 0xFFF00093 (addi x1,x0,-1) → next cycle: `imediatoGerado`=0xFFFFFFFF, `fmt`=1, `out_valid`=1.
- Back-to-back stream with `out_ready`=1, one instruction per cycle:
  - 0xFE112E23 (sw −4) → 0xFFFFFFFC, `fmt` 2.
  - 0xFE000CE3 (beq −8) → 0xFFFFFFF8, `fmt` 3.
  - 0x123452B7 (lui 0x12345) → 0x12345000, `fmt` 4.
  - 0x001000EF (jal +2048) → 0x00000800, `fmt` 5.
  - Results appear on consecutive cycles.
- 0x00509093 (slli x1,x1,5) → 0x00000005, `fmt` 6. With XLEN=64: 0x02009093 → 0x20, and 0xFFF00093 → 0xFFFFFFFFFFFFFFFF.
- Backpressure: accept 0xFFF00093, hold `out_ready`=0 for 3 cycles while presenting 0x123452B7.
  - During the stall: `in_ready`=0 and the output holds 0xFFFFFFFF.
  - On the `out_ready` rise: 0x123452B7 is accepted and 0x12345000 appears the next cycle.
- Illegal input: 0x0000007F three times → `illegal`=1, immediate 0, `ill_cnt`=3.
  - `cnt_clear` together with a fourth illegal accept → `ill_cnt`=0.
  - With CNT_W=2: five illegal accepts saturate `ill_cnt` at 3.
- Assert reset while `out_valid`=1 and `out_ready`=0 → next cycle `out_valid`=0, `ill_cnt`=0, `in_ready`=1.

Source files
------------

// File: rtl/immgen_pipe.sv
// RISC-V immediate generator (I/S/B/U/J/shamt) behind a one-deep registered
// valid/ready output stage, with a saturating count of non-immediate opcodes.
module immgen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instrucao,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imediatoGerado,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] ill_cnt,
    input  logic             cnt_clear
);

    typedef enum logic [2:0] {
        F_NONE = 3'd0,
        F_I    = 3'd1,
        F_S    = 3'd2,
        F_B    = 3'd3,
        F_U    = 3'd4,
        F_J    = 3'd5,
        F_SH   = 3'd6
    } fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Signed size cast replicates bit 31 up to XLEN.
    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [6:0]              op_p0;
    logic [2:0]              f3_p0;
    logic [5:0]              shamt_p0;
    logic signed [XLEN-1:0]  imm_p0;
    fmt_t                    fmt_p0;
    logic                    ill_p0;
    logic                    accept_p0;

    logic                    vld_p1;
    logic signed [XLEN-1:0]  imm_p1;
    fmt_t                    fmt_p1;
    logic                    ill_p1;
    logic [CNT_W-1:0]        cnt_p1;

    // ---- stage p0: combinational decode ----
    assign op_p0    = instrucao[6:0];
    assign f3_p0    = instrucao[14:12];
    // RV64 shifts use a 6-bit shamt; RV32 ignores instrucao[25].
    assign shamt_p0 = (XLEN == 64) ? instrucao[25:20] : {1'b0, instrucao[24:20]};

    always_comb begin
        imm_p0 = '0;
        fmt_p0 = F_NONE;
        ill_p0 = 1'b0;
        if (op_p0 == OP_IMM && (f3_p0 == 3'b001 || f3_p0 == 3'b101)) begin
            imm_p0 = $signed(XLEN'(shamt_p0));
            fmt_p0 = F_SH;
        end else begin
            case (op_p0)
                OP_LOAD, OP_IMM, OP_JALR, OP_FENCE: begin
                    imm_p0 = sext32({{20{instrucao[31]}}, instrucao[31:20]});
                    fmt_p0 = F_I;
                end
                OP_STORE: begin
                    imm_p0 = sext32({{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]});
                    fmt_p0 = F_S;
                end
                OP_BRANCH: begin
                    imm_p0 = sext32({{19{instrucao[31]}}, instrucao[31], instrucao[7],
                                     instrucao[30:25], instrucao[11:8], 1'b0});
                    fmt_p0 = F_B;
                end
                OP_LUI, OP_AUIPC: begin
                    imm_p0 = sext32({instrucao[31:12], 12'b0});
                    fmt_p0 = F_U;
                end
                OP_JAL: begin
                    imm_p0 = sext32({{11{instrucao[31]}}, instrucao[31], instrucao[19:12],
                                     instrucao[20], instrucao[30:21], 1'b0});
                    fmt_p0 = F_J;
                end
                default: begin
                    ill_p0 = 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;

    // ---- stage p1: output register and illegal counter ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            fmt_p1 <= F_NONE;
            ill_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1 <= 1'b1;
                imm_p1 <= imm_p0;
                fmt_p1 <= fmt_p0;
                ill_p1 <= ill_p0;
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
            if (cnt_clear)
                cnt_p1 <= '0;
            else if (accept_p0 && ill_p0)
                cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_valid      = vld_p1;
    assign imediatoGerado = imm_p1;
    assign fmt            = fmt_p1;
    assign illegal        = ill_p1;
    assign ill_cnt        = cnt_p1;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: three instances (RV32/CNT_W=8, RV64, CNT_W=2)
// share one stimulus stream; expected values are hand-computed constants.
module tb_immgen_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instrucao;
    logic        out_ready;
    logic        cnt_clear;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [31:0] a_imm;
    logic [2:0]  a_fmt;
    logic [7:0]  a_cnt;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_imm;
    logic [2:0]  b_fmt;
    logic [7:0]  b_cnt;

    logic        c_in_ready, c_out_valid, c_illegal;
    logic [31:0] c_imm;
    logic [2:0]  c_fmt;
    logic [1:0]  c_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    immgen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .instrucao(instrucao), .out_valid(a_out_valid), .out_ready(out_ready),
        .imediatoGerado(a_imm), .fmt(a_fmt), .illegal(a_illegal),
        .ill_cnt(a_cnt), .cnt_clear(cnt_clear));

    immgen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .instrucao(instrucao), .out_valid(b_out_valid), .out_ready(out_ready),
        .imediatoGerado(b_imm), .fmt(b_fmt), .illegal(b_illegal),
        .ill_cnt(b_cnt), .cnt_clear(cnt_clear));

    immgen_pipe #(.XLEN(32), .CNT_W(2)) dutc2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
        .instrucao(instrucao), .out_valid(c_out_valid), .out_ready(out_ready),
        .imediatoGerado(c_imm), .fmt(c_fmt), .illegal(c_illegal),
        .ill_cnt(c_cnt), .cnt_clear(cnt_clear));

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vec [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        vec[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0}; // addi -1
        vec[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0}; // sw -4
        vec[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0}; // beq -8
        vec[3]  = '{32'h123452B7, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0}; // lui
        vec[4]  = '{32'h001000EF, 32'h00000800, 64'h0000000000000800, 3'd5, 1'b0}; // jal +2048
        vec[5]  = '{32'h00509093, 32'h00000005, 64'h0000000000000005, 3'd6, 1'b0}; // slli 5
        vec[6]  = '{32'h02009093, 32'h00000000, 64'h0000000000000020, 3'd6, 1'b0}; // slli 32 (rv64)
        vec[7]  = '{32'h40515093, 32'h00000005, 64'h0000000000000005, 3'd6, 1'b0}; // srai 5
        vec[8]  = '{32'h00412083, 32'h00000004, 64'h0000000000000004, 3'd1, 1'b0}; // lw 4
        vec[9]  = '{32'h000080E7, 32'h00000000, 64'h0000000000000000, 3'd1, 1'b0}; // jalr 0
        vec[10] = '{32'hFFFFF117, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0}; // auipc
        vec[11] = '{32'h0000000F, 32'h00000000, 64'h0000000000000000, 3'd1, 1'b0}; // fence
        vec[12] = '{32'h002081B3, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b1}; // add (R)

        // Reset with in_valid high: nothing may be captured.
        reset = 1'b1; in_valid = 1'b1; instrucao = 32'hFFF00093;
        out_ready = 1'b1; cnt_clear = 1'b0;
        step();
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_imm", a_imm, 0);
        chk("rst_fmt", a_fmt, 0);
        chk("rst_illegal", a_illegal, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_in_ready", a_in_ready, 1);

        // Back-to-back stream, one result per cycle.
        for (int i = 0; i < 13; i++) begin
            instrucao = vec[i].ins;
            in_valid = 1'b1;
            step();
            chk($sformatf("vec%0d_valid", i), a_out_valid, 1);
            chk($sformatf("vec%0d_in_ready", i), a_in_ready, 1);
            chk($sformatf("vec%0d_imm32", i), a_imm, vec[i].imm32);
            chk($sformatf("vec%0d_fmt", i), a_fmt, vec[i].fmt);
            chk($sformatf("vec%0d_illegal", i), a_illegal, vec[i].ill);
            chk($sformatf("vec%0d_imm64", i), b_imm, vec[i].imm64);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid", a_out_valid, 0);
        chk("drain_hold_imm", a_imm, 32'h0);
        chk("drain_hold_illegal", a_illegal, 1);

        // Backpressure: output holds, input stalls, then accepts on release.
        instrucao = 32'hFFF00093; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("bp_first_imm", a_imm, 32'hFFFFFFFF);
        instrucao = 32'h123452B7; out_ready = 1'b0;
        #1;
        chk("bp_in_ready_low", a_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_stall%0d_valid", i), a_out_valid, 1);
            chk($sformatf("bp_stall%0d_in_ready", i), a_in_ready, 0);
            chk($sformatf("bp_stall%0d_imm", i), a_imm, 32'hFFFFFFFF);
            chk($sformatf("bp_stall%0d_fmt", i), a_fmt, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", a_in_ready, 1);
        step();
        chk("bp_new_valid", a_out_valid, 1);
        chk("bp_new_imm", a_imm, 32'h12345000);
        chk("bp_new_fmt", a_fmt, 4);
        in_valid = 1'b0;
        step();
        chk("bp_drain_valid", a_out_valid, 0);

        // Illegal counter: count, clear priority, saturation.
        do_reset();
        instrucao = 32'h0000007F; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ill%0d_illegal", i), a_illegal, 1);
            chk($sformatf("ill%0d_imm", i), a_imm, 0);
            chk($sformatf("ill%0d_fmt", i), a_fmt, 0);
        end
        chk("ill_cnt3", a_cnt, 3);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        chk("ill_clear_cnt", a_cnt, 0);
        chk("ill_clear_cnt_c2", c_cnt, 0);
        for (int i = 0; i < 5; i++) step();
        in_valid = 1'b0;
        chk("ill_cnt5", a_cnt, 5);
        chk("ill_sat_c2", c_cnt, 3);
        step();
        chk("ill_idle_cnt", a_cnt, 5);

        // Reset while an unconsumed output is held.
        instrucao = 32'hFFF00093; in_valid = 1'b1; out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        step();
        chk("mid_held_valid", a_out_valid, 1);
        reset = 1'b1; in_valid = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);
        chk("mid_rst_imm", a_imm, 0);
        step();
        chk("mid_after_valid", a_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
